// File: rtl/sdram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_port_arbiter
// Shares one SDRAM controller slave port between two masters: the A-bus
// (default winner) and the CPU (guaranteed a turn after STARVE_LIMIT
// consecutive A grants while it waits). Reads are tracked in an owner-tag FIFO
// so returning s_readdatavalid pulses are routed back to the issuing master.
//
// Ports
//   clock, reset            : single clock, asynchronous active-high reset
//   a_* / c_*               : A-bus and CPU master commands (address, read,
//                             write, writedata, byteenable), waitrequest and
//                             readdatavalid back to each master
//   readdata                : shared read data (copy of s_readdata)
//   s_*                     : command to / response from the SDRAM controller
//   protocol_error          : sticky flag for read+write together or for read
//                             data arriving with no read outstanding
// -----------------------------------------------------------------------------
module sdram_port_arbiter #(
  parameter int ADDR_W       = 24,
  parameter int MAX_PEND     = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] a_address,
  input  logic              a_read,
  input  logic              a_write,
  input  logic [15:0]       a_writedata,
  input  logic [1:0]        a_byteenable,
  output logic              a_waitrequest,
  output logic              a_readdatavalid,
  input  logic [ADDR_W-1:0] c_address,
  input  logic              c_read,
  input  logic              c_write,
  input  logic [15:0]       c_writedata,
  input  logic [1:0]        c_byteenable,
  output logic              c_waitrequest,
  output logic              c_readdatavalid,
  output logic [15:0]       readdata,
  output logic [ADDR_W-1:0] s_address,
  output logic              s_read,
  output logic              s_write,
  output logic [15:0]       s_writedata,
  output logic [1:0]        s_byteenable,
  input  logic              s_waitrequest,
  input  logic [15:0]       s_readdata,
  input  logic              s_readdatavalid,
  output logic              protocol_error
);

  localparam int PW = $clog2(MAX_PEND);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(MAX_PEND);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_A = 2'd1,
    ST_BUSY_C = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            perr_q, perr_d;
  logic            tags_q [MAX_PEND];   // 1 = CPU owns the read, 0 = A-bus

  logic full, empty;
  logic a_req, c_req, a_elig, c_elig;
  logic a_stall, c_stall;
  logic a_grant, c_grant;
  logic push, push_tag, pop, head_tag, rw_err;

  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == {CW{1'b0}});
  assign a_req = a_read | a_write;
  assign c_req = c_read | c_write;

  // Read+write together is treated as a read, so it needs a free FIFO slot.
  assign a_elig = (a_write & ~a_read) | (a_read & ~full);
  assign c_elig = (c_write & ~c_read) | (c_read & ~full);

  // A read is never accepted into a full tracker, even if the master changes
  // its command from write to read while already holding the port.
  assign a_stall = s_waitrequest | (a_read & full);
  assign c_stall = s_waitrequest | (c_read & full);

  assign pop      = s_readdatavalid & ~empty;
  assign head_tag = tags_q[rd_ptr_q];

  assign a_readdatavalid = pop & ~head_tag;
  assign c_readdatavalid = pop & head_tag;
  assign readdata        = s_readdata;
  assign protocol_error  = perr_q;

  // Arbitration FSM next state and slave command mux.
  always_comb begin
    state_d       = state_q;
    s_address     = {ADDR_W{1'b0}};
    s_read        = 1'b0;
    s_write       = 1'b0;
    s_writedata   = 16'h0000;
    s_byteenable  = 2'b00;
    a_waitrequest = 1'b1;
    c_waitrequest = 1'b1;
    a_grant       = 1'b0;
    c_grant       = 1'b0;
    push          = 1'b0;
    push_tag      = 1'b0;
    rw_err        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (c_elig && ((starve_q == STARVE_MAX) || !a_elig)) begin
          state_d = ST_BUSY_C;
          c_grant = 1'b1;
        end else if (a_elig) begin
          state_d = ST_BUSY_A;
          a_grant = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY_A: begin
        s_address     = a_address;
        s_read        = a_read & ~full;
        s_write       = a_write & ~a_read;
        s_writedata   = a_writedata;
        s_byteenable  = a_byteenable;
        a_waitrequest = a_stall;
        rw_err        = a_read & a_write;
        // Dropped request or accepted command both end the tenure.
        if (!a_req || !a_stall) begin
          state_d  = ST_IDLE;
          push     = a_read & ~a_stall;
          push_tag = 1'b0;
        end else begin
          state_d = ST_BUSY_A;
        end
      end
      ST_BUSY_C: begin
        s_address     = c_address;
        s_read        = c_read & ~full;
        s_write       = c_write & ~c_read;
        s_writedata   = c_writedata;
        s_byteenable  = c_byteenable;
        c_waitrequest = c_stall;
        rw_err        = c_read & c_write;
        if (!c_req || !c_stall) begin
          state_d  = ST_IDLE;
          push     = c_read & ~c_stall;
          push_tag = 1'b1;
        end else begin
          state_d = ST_BUSY_C;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Starvation counter, read-tracker pointers/count and sticky error.
  always_comb begin
    starve_d = starve_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (!c_req || c_grant) begin
      starve_d = {SW{1'b0}};
    end else if (a_grant && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + SW'(1);
    end else begin
      starve_d = starve_q;
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    perr_d = perr_q | rw_err | (s_readdatavalid & empty);
  end

  // State and bookkeeping registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      starve_q <= {SW{1'b0}};
      cnt_q    <= {CW{1'b0}};
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      perr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      perr_q   <= perr_d;
    end
  end

  // Owner-tag storage for outstanding reads.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MAX_PEND; i++) begin
        tags_q[i] <= 1'b0;
      end
    end else if (push) begin
      tags_q[wr_ptr_q] <= push_tag;
    end
  end

endmodule
